// File: rtl/palindrome_pkg.sv
// Shared types and helpers for the serial palindrome detector.
//   state_t    : detector state (window filling / evaluating every accept)
//   MODE_*     : comparison mode encodings
//   clamp_len  : limits a requested window length to [2, max_len]
package palindrome_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic MODE_PAL  = 1'b0;
   localparam logic MODE_ANTI = 1'b1;

   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned max_len);
      if (len < 2)
         return 2;
      else if (len > max_len)
         return max_len;
      else
         return len;
   endfunction

endpackage

// File: rtl/palindrome_window_cmp.sv
// Combinational window comparator.
//   window_i : sliding window, bit 0 newest, bit k accepted k valid cycles earlier
//   len_i    : active window length (2..MAX_LEN)
//   mode_i   : MODE_PAL -> pairs must be equal, MODE_ANTI -> pairs must differ
//   match_o  : every active pair (i, len-1-i), i < len/2, satisfies the mode test
module palindrome_window_cmp #(
   parameter int MAX_LEN = 8,
   localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
   input  logic [MAX_LEN-1:0] window_i,
   input  logic [LEN_W-1:0]   len_i,
   input  logic               mode_i,
   output logic               match_o
);

   localparam int NPAIR = MAX_LEN / 2;

   // Variable-index bit select written as a mux so the index width need not
   // match the window's address width.
   function automatic logic pick(input logic [MAX_LEN-1:0] w, input logic [LEN_W-1:0] idx);
      logic b;
      b = 1'b0;
      for (int k = 0; k < MAX_LEN; k++)
         if (idx == LEN_W'(k))
            b = w[k];
      return b;
   endfunction

   logic [NPAIR-1:0] pair_ok;

   for (genvar i = 0; i < NPAIR; i++) begin : g_pair
      logic             en;
      logic [LEN_W-1:0] hi_idx;
      logic             hi_bit;

      assign en      = LEN_W'(i) < (len_i >> 1);
      assign hi_idx  = len_i - LEN_W'(i + 1);
      assign hi_bit  = pick(window_i, hi_idx);
      // Disabled pairs (beyond len/2, incl. the middle bit of odd lengths) pass.
      assign pair_ok[i] = !en || ((window_i[i] ^ hi_bit) == mode_i);
   end

   assign match_o = &pair_ok;

endmodule

// File: rtl/palindrome_nb.sv
// Serial palindrome / anti-palindrome detector with runtime length and mode.
//   clk, reset      : rising-edge clock, synchronous active-low reset
//   x_i, valid_i    : serial bit and its accept qualifier
//   clear_i         : flush window/fill/counter and latch len_i, mode_i
//   palindrome_o    : result of the last evaluated window (level)
//   valid_o         : one-cycle strobe when palindrome_o was updated
//   fill_o          : bits held, saturating at MAX_LEN
//   pal_count_o     : saturating count of matches since reset/clear
//
// state   | meaning
// ST_FILL | fewer than len_q bits held, no results produced
// ST_RUN  | window full, every accept produces a result
module palindrome_nb
   import palindrome_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x_i,
   input  logic             valid_i,
   input  logic             clear_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             mode_i,
   output logic             palindrome_o,
   output logic             valid_o,
   output logic [LEN_W-1:0] fill_o,
   output logic [CNT_W-1:0] pal_count_o
);

   logic [MAX_LEN-1:0] win_q, win_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [LEN_W-1:0]   len_q;
   logic               mode_q;
   state_t             state_q;
   logic               pal_q, vld_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               match;
   logic               eval_d;

   if (MAX_LEN > 1) begin : g_shift
      assign win_d = {win_q[MAX_LEN-2:0], x_i};
   end

   assign fill_d = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
   assign eval_d = (state_q == ST_RUN) || (fill_d >= len_q);

   palindrome_window_cmp #(.MAX_LEN(MAX_LEN)) u_cmp (
      .window_i (win_d),
      .len_i    (len_q),
      .mode_i   (mode_q),
      .match_o  (match)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         win_q   <= '0;
         fill_q  <= '0;
         len_q   <= LEN_W'(MAX_LEN);
         mode_q  <= MODE_PAL;
         state_q <= ST_FILL;
         pal_q   <= 1'b0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (clear_i) begin
         win_q   <= '0;
         fill_q  <= '0;
         len_q   <= LEN_W'(clamp_len(32'(len_i), 32'(MAX_LEN)));
         mode_q  <= mode_i;
         state_q <= ST_FILL;
         pal_q   <= 1'b0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (valid_i) begin
         win_q  <= win_d;
         fill_q <= fill_d;
         vld_q  <= eval_d;
         if (eval_d) begin
            state_q <= ST_RUN;
            pal_q   <= match;
            // Count moves with the registered result so both are seen together.
            if (match && (cnt_q != '1))
               cnt_q <= cnt_q + CNT_W'(1);
         end
      end else begin
         vld_q <= 1'b0;
      end
   end

   assign palindrome_o = pal_q;
   assign valid_o      = vld_q;
   assign fill_o       = fill_q;
   assign pal_count_o  = cnt_q;

endmodule

// File: tb/tb_palindrome_nb.sv
module tb_palindrome_nb;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;

   logic             clk = 1'b0;
   logic             reset, x_i, valid_i, clear_i, mode_i;
   logic [LEN_W-1:0] len_i;
   logic             pal_a, vld_a, pal_b, vld_b;
   logic [LEN_W-1:0] fill_a, fill_b;
   logic [15:0]      cnt_a;
   logic [1:0]       cnt_b;

   always #5 clk = ~clk;

   palindrome_nb #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .x_i(x_i), .valid_i(valid_i), .clear_i(clear_i),
      .len_i(len_i), .mode_i(mode_i), .palindrome_o(pal_a), .valid_o(vld_a),
      .fill_o(fill_a), .pal_count_o(cnt_a)
   );

   palindrome_nb #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .x_i(x_i), .valid_i(valid_i), .clear_i(clear_i),
      .len_i(len_i), .mode_i(mode_i), .palindrome_o(pal_b), .valid_o(vld_b),
      .fill_o(fill_b), .pal_count_o(cnt_b)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: history of accepted bits, newest first.
   bit m_hist[$];
   int m_fill, m_len, m_cnt;
   bit m_mode, m_pal, m_vld;

   function automatic bit window_matches();
      for (int i = 0; i < m_len / 2; i++) begin
         if (m_mode == 1'b0 && m_hist[i] != m_hist[m_len-1-i]) return 1'b0;
         if (m_mode == 1'b1 && m_hist[i] == m_hist[m_len-1-i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model(input bit r, input bit c, input int l, input bit m, input bit v, input bit xb);
      if (!r) begin
         m_hist.delete(); m_fill = 0; m_len = MAX_LEN; m_mode = 0;
         m_pal = 0; m_vld = 0; m_cnt = 0;
      end else if (c) begin
         m_hist.delete(); m_fill = 0; m_cnt = 0; m_pal = 0; m_vld = 0;
         m_len = (l < 2) ? 2 : (l > MAX_LEN) ? MAX_LEN : l;
         m_mode = m;
      end else if (v) begin
         m_hist.push_front(xb);
         if (m_hist.size() > MAX_LEN) void'(m_hist.pop_back());
         if (m_fill < MAX_LEN) m_fill++;
         m_vld = (m_fill >= m_len);
         if (m_vld) begin
            m_pal = window_matches();
            if (m_pal) m_cnt++;
         end
      end else begin
         m_vld = 0;
      end
   endtask

   task automatic step(input bit r, input bit c, input int l, input bit m, input bit v, input bit xb);
      reset = r; clear_i = c; len_i = LEN_W'(l); mode_i = m; valid_i = v; x_i = xb;
      @(posedge clk);
      model(r, c, l, m, v, xb);
      #1;
   endtask

   typedef struct {
      bit r, c; int l; bit m, v, x;
      bit e_pal, e_vld; int e_fill, e_cnt, e_cnt2;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit r, input bit c, input int l, input bit m, input bit v, input bit x,
                      input bit ep, input bit ev, input int ef, input int ec, input int ec2);
      vec_t t;
      t = '{r:r, c:c, l:l, m:m, v:v, x:x, e_pal:ep, e_vld:ev, e_fill:ef, e_cnt:ec, e_cnt2:ec2};
      tbl.push_back(t);
   endtask

   initial begin
      reset = 0; x_i = 0; valid_i = 0; clear_i = 0; len_i = '0; mode_i = 0;

      //   r c  l m v x   pal vld fill cnt cnt2
      add(0,0, 0,0,0,0,  0,0,0,0,0);
      // len 3 palindrome, then two non-palindromic windows
      add(1,1, 3,0,0,0,  0,0,0,0,0);
      add(1,0, 0,0,1,1,  0,0,1,0,0);
      add(1,0, 0,0,1,0,  0,0,2,0,0);
      add(1,0, 0,0,1,1,  1,1,3,1,1);
      add(1,0, 0,0,1,1,  0,1,4,1,1);
      add(1,0, 0,0,1,0,  0,1,5,1,1);
      // len 4 anti-palindrome with gaps
      add(1,1, 4,1,0,0,  0,0,0,0,0);
      add(1,0, 0,0,1,1,  0,0,1,0,0);
      add(1,0, 0,0,0,0,  0,0,1,0,0);
      add(1,0, 0,0,1,1,  0,0,2,0,0);
      add(1,0, 0,0,0,1,  0,0,2,0,0);
      add(1,0, 0,0,1,0,  0,0,3,0,0);
      add(1,0, 0,0,0,0,  0,0,3,0,0);
      add(1,0, 0,0,1,0,  1,1,4,1,1);
      add(1,0, 0,0,0,1,  1,0,4,1,1);
      add(1,0, 0,0,0,0,  1,0,4,1,1);
      // len clamp low
      add(1,1, 0,0,0,0,  0,0,0,0,0);
      add(1,0, 0,0,1,0,  0,0,1,0,0);
      add(1,0, 0,0,1,0,  1,1,2,1,1);
      // len clamp high: first result on the 8th bit
      add(1,1,15,0,0,0,  0,0,0,0,0);
      for (int i = 1; i <= 7; i++) add(1,0, 0,0,1,0, 0,0,i,0,0);
      add(1,0, 0,0,1,0,  1,1,8,1,1);
      add(1,0, 0,0,1,0,  1,1,8,2,2);
      // clear beats valid; bit dropped
      add(1,1, 2,0,1,1,  0,0,0,0,0);
      add(1,0, 0,0,1,1,  0,0,1,0,0);
      add(1,0, 0,0,1,1,  1,1,2,1,1);
      // reset mid-stream, then reset beats clear (len stays MAX_LEN)
      add(0,0, 0,0,1,1,  0,0,0,0,0);
      add(0,1, 2,0,0,0,  0,0,0,0,0);
      add(1,0, 0,0,1,0,  0,0,1,0,0);
      add(1,0, 0,0,1,0,  0,0,2,0,0);
      // 2-bit counter saturation with eight zeros at len 2
      add(1,1, 2,0,0,0,  0,0,0,0,0);
      add(1,0, 0,0,1,0,  0,0,1,0,0);
      for (int i = 2; i <= 8; i++) add(1,0, 0,0,1,0, 1,1,i,i-1,(i-1 > 3) ? 3 : i-1);

      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].r, tbl[k].c, tbl[k].l, tbl[k].m, tbl[k].v, tbl[k].x);
         chk($sformatf("vec%0d pal", k),  pal_a,  tbl[k].e_pal);
         chk($sformatf("vec%0d vld", k),  vld_a,  tbl[k].e_vld);
         chk($sformatf("vec%0d fill", k), fill_a, tbl[k].e_fill);
         chk($sformatf("vec%0d cnt", k),  cnt_a,  tbl[k].e_cnt);
         chk($sformatf("vec%0d cnt2", k), cnt_b,  tbl[k].e_cnt2);
      end

      // Random stream against the reference model.
      step(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 600; k++) begin
         bit r, c, m, v, xb;
         int l;
         r  = ($urandom_range(0, 99) != 0);
         c  = ($urandom_range(0, 29) == 0);
         l  = $urandom_range(0, 15);
         m  = 1'($urandom_range(0, 1));
         v  = ($urandom_range(0, 9) < 7);
         xb = 1'($urandom_range(0, 1));
         step(r, c, l, m, v, xb);
         chk($sformatf("rnd%0d pal", k),  pal_a,  m_pal);
         chk($sformatf("rnd%0d vld", k),  vld_a,  m_vld);
         chk($sformatf("rnd%0d fill", k), fill_a, m_fill);
         chk($sformatf("rnd%0d cnt", k),  cnt_a,  (m_cnt > 65535) ? 65535 : m_cnt);
         chk($sformatf("rnd%0d cnt2", k), cnt_b,  (m_cnt > 3) ? 3 : m_cnt);
         chk($sformatf("rnd%0d pal2", k), pal_b,  m_pal);
         chk($sformatf("rnd%0d vld2", k), vld_b,  m_vld);
         chk($sformatf("rnd%0d fill2", k), fill_b, m_fill);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
